// File: rtl/top_test.sv
// top_test: single-layer spiking forward-forward core with an AER input.
// Pixel events integrate weights into LIF membranes. Tick events fire the neurons
// and, in training builds, apply the FF-STDP weight update.
// After T ticks the core reports GOODNESS = sum(cnt^2) and pulses PROCESS_DONE.
// Build option: define TRAIN_EN to include the LEARN state and the weight RAM.
// Without TRAIN_EN, IS_TRAIN/IS_POS are ignored and every weight reads as W_INIT.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for REQ; latches the event and decodes it
// S_INTEG | adds w[pix][i] to v[i], one neuron per cycle
// S_FIRE  | threshold compare, spike and count, one neuron per cycle
// S_LEARN | walks all pixels, +/-1 on seen pixels for spiking neurons
// S_ACK   | ACK high until REQ falls
module top_test #(
   parameter int                         N_NEUR = 16,
   parameter int                         N_PIX  = 784,
   parameter int                         T      = 8,
   parameter int                         W_BITS = 8,
   parameter logic signed [W_BITS-1:0]   W_INIT = 8'sd2,
   parameter logic signed [15:0]         VTH    = 16'sd8
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [11:0] aerin_addr_i,
   input  logic        aerin_req_i,
   input  logic        is_pos_i,
   input  logic        is_train_i,
   output logic        aerin_ack_o,
   output logic [31:0] goodness_o,
   output logic        process_done_o
);

   localparam int NW = (N_NEUR > 1) ? $clog2(N_NEUR) : 1;
   localparam int TW = $clog2(T) + 1;

   typedef enum logic [2:0] {S_IDLE, S_INTEG, S_FIRE, S_LEARN, S_ACK} state_t;

   state_t              state_q, state_d;
   logic [9:0]          pix_q, pix_d;
   logic [NW-1:0]       nidx_q, nidx_d;
   logic [TW-1:0]       tick_q, tick_d;
   logic                ack_q, done_q, done_d;
   logic [31:0]         good_q, good_d;
   logic signed [15:0]  v_q [N_NEUR];
   logic signed [15:0]  v_d [N_NEUR];
   logic [3:0]          cnt_q [N_NEUR];
   logic [3:0]          cnt_d [N_NEUR];
   logic [N_NEUR-1:0]   spk_q, spk_d;
   logic                tick_end;
   logic signed [W_BITS-1:0] w_rd;
   logic [31:0]         sum_sq;

   function automatic logic signed [15:0] sat_add(input logic signed [15:0] a,
                                                  input logic signed [W_BITS-1:0] b);
      logic signed [16:0] s;
      s = {a[15], a} + {{(17-W_BITS){b[W_BITS-1]}}, b};
      if (s[16] != s[15]) sat_add = s[16] ? 16'sh8000 : 16'sh7FFF;
      else                sat_add = s[15:0];
   endfunction

`ifdef TRAIN_EN
   logic                      pos_q, pos_d, train_q, train_d;
   logic [9:0]                pidx_q, pidx_d;
   logic [N_PIX-1:0]          seen_q;
   logic [N_NEUR*W_BITS-1:0]  w_q [N_PIX];
   logic [N_NEUR*W_BITS-1:0]  w_row_upd;

   localparam logic signed [W_BITS-1:0] W_MAX = {1'b0, {(W_BITS-1){1'b1}}};
   localparam logic signed [W_BITS-1:0] W_MIN = {1'b1, {(W_BITS-1){1'b0}}};

   // weight read for the neuron currently being integrated
   always_comb w_rd = $signed(w_q[pix_q][nidx_q*W_BITS +: W_BITS]);

   // saturating +/-1 for every spiking neuron on the pixel row under LEARN
   always_comb begin
      w_row_upd = w_q[pidx_q];
      for (int i = 0; i < N_NEUR; i++) begin
         if (spk_q[i]) begin
            if (pos_q && ($signed(w_row_upd[i*W_BITS +: W_BITS]) != W_MAX))
               w_row_upd[i*W_BITS +: W_BITS] = w_row_upd[i*W_BITS +: W_BITS] + 1'b1;
            else if (!pos_q && ($signed(w_row_upd[i*W_BITS +: W_BITS]) != W_MIN))
               w_row_upd[i*W_BITS +: W_BITS] = w_row_upd[i*W_BITS +: W_BITS] - 1'b1;
         end
      end
   end

   // weight RAM: reset to W_INIT, written one pixel row per LEARN cycle
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int p = 0; p < N_PIX; p++) w_q[p] <= {N_NEUR{W_INIT}};
      end else if (state_q == S_LEARN && seen_q[pidx_q]) begin
         w_q[pidx_q] <= w_row_upd;
      end
   end

   // pixel-seen vector: set on integration, cleared at the end of every tick
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)                seen_q <= '0;
      else if (tick_end)           seen_q <= '0;
      else if (state_q == S_INTEG) seen_q[pix_q] <= 1'b1;
   end

   // training controls and LEARN pixel index
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         pos_q   <= 1'b0;
         train_q <= 1'b0;
         pidx_q  <= '0;
      end else begin
         pos_q   <= pos_d;
         train_q <= train_d;
         pidx_q  <= pidx_d;
      end
   end
`else
   logic unused_cfg;
   assign unused_cfg = is_pos_i ^ is_train_i;
   always_comb w_rd = W_INIT;
`endif

   // next-state and event decode
   always_comb begin
      state_d  = state_q;
      pix_d    = pix_q;
      nidx_d   = nidx_q;
      tick_end = 1'b0;
`ifdef TRAIN_EN
      pos_d    = pos_q;
      train_d  = train_q;
      pidx_d   = pidx_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (aerin_req_i) begin
               pix_d  = aerin_addr_i[9:0];
               nidx_d = '0;
`ifdef TRAIN_EN
               pos_d   = is_pos_i;
               train_d = is_train_i;
               pidx_d  = '0;
`endif
               if (aerin_addr_i[11])                     state_d = S_ACK;
               else if (aerin_addr_i[10])                state_d = S_FIRE;
               else if (32'(aerin_addr_i[9:0]) >= N_PIX) state_d = S_ACK;
               else                                      state_d = S_INTEG;
            end
         end
         S_INTEG: begin
            nidx_d = nidx_q + 1'b1;
            if (nidx_q == NW'(N_NEUR-1)) state_d = S_ACK;
         end
         S_FIRE: begin
            nidx_d = nidx_q + 1'b1;
            if (nidx_q == NW'(N_NEUR-1)) begin
`ifdef TRAIN_EN
               if (train_q) begin
                  state_d = S_LEARN;
               end else begin
                  state_d  = S_ACK;
                  tick_end = 1'b1;
               end
`else
               state_d  = S_ACK;
               tick_end = 1'b1;
`endif
            end
         end
`ifdef TRAIN_EN
         S_LEARN: begin
            pidx_d = pidx_q + 1'b1;
            if (pidx_q == 10'(N_PIX-1)) begin
               state_d  = S_ACK;
               tick_end = 1'b1;
            end
         end
`endif
         S_ACK: begin
            if (!aerin_req_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // neuron datapath: integrate, fire, and sample-end goodness
   always_comb begin
      v_d    = v_q;
      cnt_d  = cnt_q;
      spk_d  = spk_q;
      good_d = good_q;
      done_d = 1'b0;
      tick_d = tick_q;
      sum_sq = '0;
      if (state_q == S_INTEG) begin
         v_d[nidx_q] = sat_add(v_q[nidx_q], w_rd);
      end
      if (state_q == S_FIRE) begin
         if (v_q[nidx_q] >= VTH) begin
            spk_d[nidx_q] = 1'b1;
            v_d[nidx_q]   = '0;
            if (cnt_q[nidx_q] != 4'hF) cnt_d[nidx_q] = cnt_q[nidx_q] + 1'b1;
         end else begin
            spk_d[nidx_q] = 1'b0;
         end
      end
      if (tick_end) begin
         tick_d = tick_q + 1'b1;
         if (tick_q == TW'(T-1)) begin
            for (int i = 0; i < N_NEUR; i++)
               sum_sq = sum_sq + 32'(cnt_d[i]) * 32'(cnt_d[i]);
            good_d = sum_sq;
            done_d = 1'b1;
            tick_d = '0;
            for (int i = 0; i < N_NEUR; i++) begin
               cnt_d[i] = '0;
               v_d[i]   = '0;
            end
         end
      end
   end

   // state, control and neuron registers
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= S_IDLE;
         pix_q   <= '0;
         nidx_q  <= '0;
         tick_q  <= '0;
         ack_q   <= 1'b0;
         done_q  <= 1'b0;
         good_q  <= '0;
         spk_q   <= '0;
         for (int i = 0; i < N_NEUR; i++) begin
            v_q[i]   <= '0;
            cnt_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         pix_q   <= pix_d;
         nidx_q  <= nidx_d;
         tick_q  <= tick_d;
         ack_q   <= (state_d == S_ACK);
         done_q  <= done_d;
         good_q  <= good_d;
         spk_q   <= spk_d;
         v_q     <= v_d;
         cnt_q   <= cnt_d;
      end
   end

   assign aerin_ack_o    = ack_q;
   assign goodness_o     = good_q;
   assign process_done_o = done_q;

endmodule

// File: tb/tb_top_test.sv
// Directed bench for top_test: handshake latency, sample goodness,
// ignored events, held REQ, training updates and reset during ACK.
module tb_top_test;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [11:0] addr;
   logic        req;
   logic        is_pos;
   logic        is_train;
   logic        ack;
   logic [31:0] goodness;
   logic        done;

   int checks = 0;
   int errors = 0;
   int done_seen = 0;

   localparam logic [11:0] TICK = 12'h4FF;
   localparam logic [11:0] PIX5 = 12'h005;
`ifdef TRAIN_EN
   localparam int TRAIN_TICK_LAT = 801;
   localparam int TRAIN_GOOD     = 144;
`else
   localparam int TRAIN_TICK_LAT = 17;
   localparam int TRAIN_GOOD     = 64;
`endif

   top_test dut (
      .clk_i          (clk),
      .rst_n_i        (rst_n),
      .aerin_addr_i   (addr),
      .aerin_req_i    (req),
      .is_pos_i       (is_pos),
      .is_train_i     (is_train),
      .aerin_ack_o    (ack),
      .goodness_o     (goodness),
      .process_done_o (done)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (rst_n && done) done_seen++;

   task automatic do_reset();
      req = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // full 4-phase handshake; returns REQ->ACK latency and DONE at ACK rise
   task automatic send_event(input logic [11:0] a, input int hold,
                             output int lat, output logic d);
      @(negedge clk);
      addr = a;
      req  = 1'b1;
      lat  = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!ack && lat < 2000);
      d = done;
      if (!ack) begin
         checks++; errors++;
         $display("FAIL ack_timeout addr=%h waited=%0d cycles", a, lat);
      end
      for (int k = 0; k < hold; k++) begin
         @(posedge clk); #1;
         checks++;
         if (ack !== 1'b1) begin
            errors++;
            $display("FAIL ack_hold cycle=%0d ack=%b want=1", k, ack);
         end
      end
      req = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (ack !== 1'b0) begin
         errors++;
         $display("FAIL ack_drop addr=%h ack=%b want=0", a, ack);
      end
   endtask

   task automatic test_reset();
      int   lat;
      logic d;
      do_reset();
      @(negedge clk);
      checks++;
      if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b want=0", ack); end
      checks++;
      if (goodness !== 32'd0) begin errors++; $display("FAIL reset_goodness got=%0d want=0", goodness); end
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
      lat = 0; d = 1'b0;
   endtask

   task automatic test_sample_fire();
      int   lat, d0;
      logic d;
      is_train = 1'b0; is_pos = 1'b1;
      d0 = done_seen;
      for (int i = 0; i < 4; i++) begin
         send_event(PIX5, 0, lat, d);
         if (i == 0) begin
            checks++;
            if (lat != 17) begin errors++; $display("FAIL pixel_latency got=%0d want=17", lat); end
         end
      end
      for (int t = 1; t <= 8; t++) begin
         send_event(TICK, 0, lat, d);
         if (t == 1) begin
            checks++;
            if (lat != 17) begin errors++; $display("FAIL tick_latency got=%0d want=17", lat); end
         end
         if (t == 7) begin
            checks++;
            if (goodness !== 32'd0 || done_seen != d0) begin
               errors++;
               $display("FAIL early_done goodness=%0d pulses=%0d want 0/0", goodness, done_seen - d0);
            end
         end
         if (t == 8) begin
            checks++;
            if (d !== 1'b1) begin errors++; $display("FAIL done_at_ack got=%b want=1", d); end
         end
      end
      repeat (3) @(negedge clk);
      checks++;
      if (goodness !== 32'd16) begin errors++; $display("FAIL fire_goodness got=%0d want=16", goodness); end
      checks++;
      if (done_seen - d0 != 1) begin errors++; $display("FAIL fire_done_pulses got=%0d want=1", done_seen - d0); end
   endtask

   task automatic test_empty_sample();
      int   lat, d0;
      logic d;
      d0 = done_seen;
      for (int t = 0; t < 8; t++) send_event(TICK, 0, lat, d);
      repeat (3) @(negedge clk);
      checks++;
      if (goodness !== 32'd0) begin errors++; $display("FAIL empty_goodness got=%0d want=0", goodness); end
      checks++;
      if (done_seen - d0 != 1) begin errors++; $display("FAIL empty_done_pulses got=%0d want=1", done_seen - d0); end
   endtask

   task automatic test_ignored();
      int   lat;
      logic d;
      do_reset();
      is_train = 1'b0;
      for (int i = 0; i < 3; i++) send_event(PIX5, 0, lat, d);
      send_event(12'd800, 0, lat, d);
      checks++;
      if (lat != 1) begin errors++; $display("FAIL pix800_latency got=%0d want=1", lat); end
      send_event(12'h805, 0, lat, d);
      checks++;
      if (lat != 1) begin errors++; $display("FAIL ignore_latency got=%0d want=1", lat); end
      for (int t = 0; t < 8; t++) send_event(TICK, 0, lat, d);
      checks++;
      if (goodness !== 32'd0) begin errors++; $display("FAIL ignored_goodness got=%0d want=0", goodness); end
   endtask

   task automatic test_hold_req();
      int   lat;
      logic d;
      do_reset();
      is_train = 1'b0;
      send_event(PIX5, 10, lat, d);
      send_event(PIX5, 0, lat, d);
      send_event(PIX5, 0, lat, d);
      for (int t = 0; t < 8; t++) send_event(TICK, 0, lat, d);
      checks++;
      if (goodness !== 32'd0) begin errors++; $display("FAIL hold_goodness got=%0d want=0", goodness); end
   endtask

   task automatic test_train();
      int   lat;
      logic d;
      do_reset();
      is_train = 1'b1; is_pos = 1'b1;
      for (int i = 0; i < 4; i++) send_event(PIX5, 0, lat, d);
      send_event(TICK, 0, lat, d);
      checks++;
      if (lat != TRAIN_TICK_LAT) begin
         errors++; $display("FAIL train_tick_latency got=%0d want=%0d", lat, TRAIN_TICK_LAT);
      end
      is_train = 1'b0;
      for (int i = 0; i < 3; i++) send_event(PIX5, 0, lat, d);
      send_event(TICK, 0, lat, d);
      is_train = 1'b1; is_pos = 1'b0;
      for (int i = 0; i < 4; i++) send_event(PIX5, 0, lat, d);
      send_event(TICK, 0, lat, d);
      is_train = 1'b0;
      for (int i = 0; i < 3; i++) send_event(PIX5, 0, lat, d);
      for (int t = 0; t < 5; t++) send_event(TICK, 0, lat, d);
      checks++;
      if (goodness !== 32'(TRAIN_GOOD)) begin
         errors++; $display("FAIL train_goodness got=%0d want=%0d", goodness, TRAIN_GOOD);
      end
   endtask

   task automatic test_reset_mid();
      int   lat;
      logic d;
      @(negedge clk);
      addr = 12'h805;
      req  = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (ack !== 1'b1) begin errors++; $display("FAIL mid_ack_up got=%b want=1", ack); end
      rst_n = 1'b0;
      #1;
      checks++;
      if (ack !== 1'b0 || goodness !== 32'd0) begin
         errors++; $display("FAIL mid_reset ack=%b goodness=%0d want 0/0", ack, goodness);
      end
      req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      send_event(PIX5, 0, lat, d);
      checks++;
      if (lat != 17) begin errors++; $display("FAIL post_reset_latency got=%0d want=17", lat); end
   endtask

   initial begin
      rst_n = 1'b0; req = 1'b0; addr = '0; is_pos = 1'b0; is_train = 1'b0;
      test_reset();
      test_sample_fire();
      test_empty_sample();
      test_ignored();
      test_hold_req();
      test_train();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
